// File: rtl/vpifo_pkg.sv
// Shared constants and the push-request record for the PIFO ingress path.
package vpifo_pkg;

    localparam int VPIFO_PTW        = 16;
    localparam int VPIFO_TREE_NUM   = 5;
    localparam int VPIFO_FIFO_DEPTH = 4;
    localparam int VPIFO_TREE_W     = $clog2(VPIFO_TREE_NUM);
    localparam int VPIFO_DATA_W     = VPIFO_TREE_W + VPIFO_PTW;

    typedef struct packed {
        logic [VPIFO_TREE_W-1:0] tree_id;
        logic [VPIFO_PTW-1:0]    prio;
        logic [VPIFO_DATA_W-1:0] data;
    } push_req_t;

endpackage

// File: rtl/task_ingress_fifo.sv
// Per-port request FIFO; full is a pure function of the stored count,
// so a same-cycle read never frees a slot for a write.
module task_ingress_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         i_clk,
    input  logic         i_arst,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_empty,
    output logic         o_full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          wr_ok, rd_ok;

    assign o_empty   = (cnt_q == '0);
    assign o_full    = (cnt_q == (AW+1)'(DEPTH));
    assign o_rd_data = mem[rd_ptr_q];
    assign wr_ok     = i_wr_en & ~o_full;
    assign rd_ok     = i_rd_en & ~o_empty;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({wr_ok, rd_ok})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) mem[wr_ptr_q] <= i_wr_data;
    end

endmodule

// File: rtl/task_ingress_arbiter.sv
// Multi-port ingress into the PIFO task generator: per-port FIFOs, illegal-tree
// drop counting, and a round-robin arbiter feeding one registered push port.
module task_ingress_arbiter
    import vpifo_pkg::*;
#(
    parameter int PORTS    = 4,
    parameter int DEPTH    = VPIFO_FIFO_DEPTH,
    parameter int TREE_NUM = VPIFO_TREE_NUM,
    parameter int PTW      = VPIFO_PTW,
    parameter int MTW      = $clog2(TREE_NUM),
    parameter int DCW      = 8,
    localparam int TW      = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
    localparam int PW      = (PORTS > 1) ? $clog2(PORTS) : 1,
    localparam int DW      = MTW + PTW
) (
    input  logic                     i_clk,
    input  logic                     i_arst,
    input  logic [PORTS-1:0]         i_in_valid,
    output logic [PORTS-1:0]         o_in_ready,
    input  logic [PORTS-1:0][TW-1:0] i_in_tree_id,
    input  logic [PORTS-1:0][PTW-1:0] i_in_priority,
    input  logic [PORTS-1:0][DW-1:0] i_in_data,
    input  logic                     i_task_fifo_full,
    output logic                     o_push,
    output logic [TW-1:0]            o_push_tree_id,
    output logic [PTW-1:0]           o_push_priority,
    output logic [DW-1:0]            o_push_data,
    output logic [PW-1:0]            o_push_port,
    output logic [DCW-1:0]           o_drop_cnt
);

    localparam int EW = TW + PTW + DW;

    logic [PORTS-1:0]         legal, wr_en, drop, rd_en, empty, full;
    logic [PORTS-1:0][EW-1:0] head;

    logic [PW-1:0]  rr_q, rr_d;
    logic [PW-1:0]  gnt, cand;
    logic           found, grant;
    logic           push_q, push_d;
    logic [TW-1:0]  tree_q, tree_d;
    logic [PTW-1:0] prio_q, prio_d;
    logic [DW-1:0]  data_q, data_d;
    logic [PW-1:0]  port_q, port_d;
    logic [DCW-1:0] drop_cnt_q, drop_cnt_d;

    assign o_in_ready = ~full;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        assign legal[p] = (int'(i_in_tree_id[p]) < TREE_NUM);
        assign wr_en[p] = i_in_valid[p] & o_in_ready[p] & legal[p];
        assign drop[p]  = i_in_valid[p] & o_in_ready[p] & ~legal[p];

        task_ingress_fifo #(
            .DEPTH (DEPTH),
            .W     (EW)
        ) u_fifo (
            .i_clk     (i_clk),
            .i_arst    (i_arst),
            .i_wr_en   (wr_en[p]),
            .i_wr_data ({i_in_tree_id[p], i_in_priority[p], i_in_data[p]}),
            .i_rd_en   (rd_en[p]),
            .o_rd_data (head[p]),
            .o_empty   (empty[p]),
            .o_full    (full[p])
        );
    end

    // Several ports may present illegal trees in the same cycle.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        for (int p = 0; p < PORTS; p++) begin
            if (drop[p] && (drop_cnt_d != '1)) drop_cnt_d = drop_cnt_d + DCW'(1);
        end
    end

    always_comb begin
        found  = 1'b0;
        gnt    = '0;
        cand   = '0;
        for (int i = 0; i < PORTS; i++) begin
            cand = PW'((int'(rr_q) + i) % PORTS);
            if (!found && !empty[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
        grant  = found & ~i_task_fifo_full;
        rd_en  = '0;
        rr_d   = rr_q;
        push_d = grant;
        tree_d = '0;
        prio_d = '0;
        data_d = '0;
        port_d = '0;
        if (grant) begin
            rd_en[gnt]               = 1'b1;
            rr_d                     = PW'((int'(gnt) + 1) % PORTS);
            {tree_d, prio_d, data_d} = head[gnt];
            port_d                   = gnt;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rr_q       <= '0;
            push_q     <= 1'b0;
            tree_q     <= '0;
            prio_q     <= '0;
            data_q     <= '0;
            port_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            rr_q       <= rr_d;
            push_q     <= push_d;
            tree_q     <= tree_d;
            prio_q     <= prio_d;
            data_q     <= data_d;
            port_q     <= port_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_push          = push_q;
    assign o_push_tree_id  = tree_q;
    assign o_push_priority = prio_q;
    assign o_push_data     = data_q;
    assign o_push_port     = port_q;
    assign o_drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_task_ingress_arbiter.sv
// Scoreboard bench for task_ingress_arbiter: latency, fairness, backpressure,
// drop saturation, wrap/order and mid-stream reset.
module tb_task_ingress_arbiter;
    import vpifo_pkg::*;

    logic             clk = 1'b0;
    logic             arst;
    logic [3:0]       valid;
    logic [3:0]       ready;
    logic [3:0][2:0]  tree;
    logic [3:0][15:0] prio;
    logic [3:0][18:0] data;
    logic             full;
    logic             o_push;
    logic [2:0]       o_tree;
    logic [15:0]      o_prio;
    logic [18:0]      o_data;
    logic [1:0]       o_port;
    logic [7:0]       o_drop;

    typedef struct {
        int        port;
        push_req_t req;
    } exp_t;

    exp_t        sb[$];
    int          push_log[$];
    logic [18:0] data_log[$];
    int          cyc_log[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          mon_k;

    task_ingress_arbiter dut (
        .i_clk            (clk),
        .i_arst           (arst),
        .i_in_valid       (valid),
        .o_in_ready       (ready),
        .i_in_tree_id     (tree),
        .i_in_priority    (prio),
        .i_in_data        (data),
        .i_task_fifo_full (full),
        .o_push           (o_push),
        .o_push_tree_id   (o_tree),
        .o_push_priority  (o_prio),
        .o_push_data      (o_data),
        .o_push_port      (o_port),
        .o_drop_cnt       (o_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every push must match the oldest outstanding entry of its own port.
    always @(negedge clk) begin
        if (!arst) begin
            checks++;
            if (o_push) begin
                mon_k = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (mon_k < 0 && sb[i].port == int'(o_port)) mon_k = i;
                if (mon_k < 0) begin
                    errors++;
                    $display("FAIL unexpected_push: got port=%0d data=%0h, required no push", o_port, o_data);
                end else begin
                    if ({o_tree, o_prio, o_data} !== sb[mon_k].req) begin
                        errors++;
                        $display("FAIL push_fields port %0d: got %h, required %h", o_port,
                                 {o_tree, o_prio, o_data}, sb[mon_k].req);
                    end
                    sb.delete(mon_k);
                end
                push_log.push_back(int'(o_port));
                data_log.push_back(o_data);
                cyc_log.push_back(cyc);
            end else if ({o_tree, o_prio, o_data, o_port} !== '0) begin
                errors++;
                $display("FAIL idle_fields: got %h, required 0", {o_tree, o_prio, o_data, o_port});
            end
        end
    end

    task automatic clear_logs();
        push_log.delete();
        data_log.delete();
        cyc_log.delete();
    endtask

    task automatic send(input int p, input int t, input int pr, input int d);
        exp_t e;
        int   w = 0;
        @(negedge clk);
        valid[p] = 1'b1;
        tree[p]  = 3'(t);
        prio[p]  = 16'(pr);
        data[p]  = 19'(d);
        while (!ready[p] && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ready[p]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout port %0d: got ready=0, required 1", p);
        end else if (t < 5) begin
            e.port         = p;
            e.req.tree_id  = 3'(t);
            e.req.prio     = 16'(pr);
            e.req.data     = 19'(d);
            sb.push_back(e);
        end
        @(posedge clk);
        #1 valid[p] = 1'b0;
    endtask

    task automatic wait_pushes(input int n, input int budget, output bit ok);
        int c = 0;
        while (push_log.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        ok = (push_log.size() >= n);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        arst = 1'b1;
        full = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        arst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({o_push, o_tree, o_prio, o_data, o_port} !== '0) begin
            errors++;
            $display("FAIL reset_push: got %h, required 0", {o_push, o_tree, o_prio, o_data, o_port});
        end
        checks++;
        if (o_drop !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop: got %0d, required 0", o_drop);
        end
        checks++;
        if (ready !== 4'hF) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1111", ready);
        end
        arst = 1'b0;
        clear_logs();
    endtask

    task automatic test_single();
        exp_t e;
        @(negedge clk);
        valid[1] = 1'b1; tree[1] = 3'd2; prio[1] = 16'd1; data[1] = 19'd1;
        e.port = 1; e.req.tree_id = 3'd2; e.req.prio = 16'd1; e.req.data = 19'd1;
        sb.push_back(e);
        @(posedge clk);
        #1 valid[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (o_push !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got o_push=%b one edge after accept, required 0", o_push);
        end
        @(negedge clk);
        checks++;
        if ({o_push, o_port, o_tree, o_prio, o_data} !== {1'b1, 2'd1, 3'd2, 16'd1, 19'd1}) begin
            errors++;
            $display("FAIL single_push: got push=%b port=%0d tree=%0d prio=%0d data=%0d, required 1 1 2 1 1",
                     o_push, o_port, o_tree, o_prio, o_data);
        end
        @(negedge clk);
        checks++;
        if (o_push !== 1'b0) begin
            errors++;
            $display("FAIL single_once: got o_push=%b, required 0", o_push);
        end
    endtask

    task automatic test_fairness();
        bit ok;
        apply_reset();
        full = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < 4; p++)
                send(p, (p + r) % 5, int'($urandom_range(0, 65535)), p * 16 + r);
        clear_logs();
        @(negedge clk);
        full = 1'b0;
        wait_pushes(12, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fair_count: got %0d pushes, required 12", push_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (push_log[i] != i % 4) begin
                    errors++;
                    $display("FAIL fair_grant[%0d]: got port %0d, required %0d", i, push_log[i], i % 4);
                end
            end
            checks++;
            if (cyc_log[11] - cyc_log[0] != 11) begin
                errors++;
                $display("FAIL fair_rate: got span %0d cycles, required 11", cyc_log[11] - cyc_log[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int exp_seq[6] = '{2, 0, 2, 0, 0, 0};
        apply_reset();
        send(0, 1, 10, 100);
        wait_pushes(1, 20, ok);
        clear_logs();
        full = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 2, 20 + i, 200 + i);
        checks++;
        if (ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready: got ready[0]=%b after %0d accepts, required 0", ready[0], 4);
        end
        send(2, 3, 30, 300);
        send(2, 3, 31, 301);
        @(negedge clk);
        valid[0] = 1'b1; data[0] = 19'h7ffff;
        repeat (5) @(negedge clk);
        valid[0] = 1'b0;
        checks++;
        if (push_log.size() != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d pushes while full, required 0", push_log.size());
        end
        full = 1'b0;
        wait_pushes(6, 40, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (push_log.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d pushes, required 6", push_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (push_log[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL bp_grant[%0d]: got port %0d, required %0d", i, push_log[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        send(3, 7, 1, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (push_log.size() != 0 || o_drop !== 8'd1) begin
            errors++;
            $display("FAIL drop_first: got pushes=%0d drop=%0d, required 0 1", push_log.size(), o_drop);
        end
        send(1, 5, 2, 2);
        send(1, 4, 3, 3);
        repeat (3) @(negedge clk);
        checks++;
        if (push_log.size() != 1 || o_drop !== 8'd2) begin
            errors++;
            $display("FAIL drop_boundary: got pushes=%0d drop=%0d, required 1 2", push_log.size(), o_drop);
        end
        for (int i = 2; i < 255; i++) send(i % 4, 7, i, i);
        @(negedge clk);
        checks++;
        if (o_drop !== 8'd255) begin
            errors++;
            $display("FAIL drop_255: got %0d, required 255", o_drop);
        end
        for (int i = 255; i < 300; i++) send(i % 4, 7, i, i);
        @(negedge clk);
        checks++;
        if (o_drop !== 8'd255 || push_log.size() != 1) begin
            errors++;
            $display("FAIL drop_sat: got drop=%0d pushes=%0d, required 255 1", o_drop, push_log.size());
        end
    endtask

    task automatic test_wrap_order();
        bit ok;
        apply_reset();
        fork
            begin
                for (int i = 0; i < 10; i++) send(0, i % 5, i + 1, i);
            end
            begin
                repeat (40) begin
                    @(negedge clk);
                    full = 1'($urandom_range(0, 1));
                end
                full = 1'b0;
            end
        join
        full = 1'b0;
        wait_pushes(10, 60, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (data_log.size() != 10) begin
            errors++;
            $display("FAIL wrap_count: got %0d pushes, required 10", data_log.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (data_log[i] !== 19'(i)) begin
                    errors++;
                    $display("FAIL wrap_data[%0d]: got %0d, required %0d", i, data_log[i], i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int exp_seq[3] = '{0, 2, 3};
        apply_reset();
        send(1, 0, 5, 5);
        wait_pushes(1, 20, ok);
        full = 1'b1;
        for (int i = 0; i < 3; i++) send(1, 1, 6 + i, 6 + i);
        @(negedge clk);
        #2 arst = 1'b1;
        sb.delete();
        full = 1'b0;
        #1;
        checks++;
        if ({o_push, o_tree, o_prio, o_data, o_port, o_drop} !== '0 || ready !== 4'hF) begin
            errors++;
            $display("FAIL midrst_outputs: got push=%b fields=%h drop=%0d ready=%b, required 0 0 0 1111",
                     o_push, {o_tree, o_prio, o_data, o_port}, o_drop, ready);
        end
        repeat (2) @(negedge clk);
        arst = 1'b0;
        clear_logs();
        repeat (5) @(negedge clk);
        checks++;
        if (push_log.size() != 0) begin
            errors++;
            $display("FAIL midrst_flush: got %0d pushes after release, required 0", push_log.size());
        end
        full = 1'b1;
        send(3, 2, 9, 9);
        send(2, 1, 16'h1234, 19'h55);
        send(0, 3, 7, 7);
        @(negedge clk);
        full = 1'b0;
        wait_pushes(3, 30, ok);
        checks++;
        if (push_log.size() != 3) begin
            errors++;
            $display("FAIL midrst_count: got %0d pushes, required 3", push_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (push_log[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL midrst_grant[%0d]: got port %0d, required %0d", i, push_log[i], exp_seq[i]);
                end
            end
            checks++;
            if (data_log[1] !== 19'h55) begin
                errors++;
                $display("FAIL midrst_port2: got data %h, required 55", data_log[1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000ns, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arst  = 1'b1;
        valid = '0;
        tree  = '0;
        prio  = '0;
        data  = '0;
        full  = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_illegal();
        test_wrap_order();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d unpushed entries, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
